// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: valid/ready request channel plus
// a response channel carrying read data or a write acknowledge.
interface load_store_unit_if #(
  parameter int XLEN     = 32,
  parameter int BE_WIDTH = XLEN / 8
) ();

  logic                o_Mem_Req_Valid;
  logic                i_Mem_Req_Ready;
  logic [XLEN-1:0]     o_Mem_Addr;
  logic                o_Mem_Write_Enable;
  logic [BE_WIDTH-1:0] o_Mem_Byte_Enable;
  logic [XLEN-1:0]     o_Mem_Write_Data;
  logic                i_Mem_Resp_Valid;
  logic [XLEN-1:0]     i_Mem_Read_Data;

  // The unit issues requests; the memory answers them.
  modport master (
    output o_Mem_Req_Valid,
    output o_Mem_Addr,
    output o_Mem_Write_Enable,
    output o_Mem_Byte_Enable,
    output o_Mem_Write_Data,
    input  i_Mem_Req_Ready,
    input  i_Mem_Resp_Valid,
    input  i_Mem_Read_Data
  );

  modport slave (
    input  o_Mem_Req_Valid,
    input  o_Mem_Addr,
    input  o_Mem_Write_Enable,
    input  o_Mem_Byte_Enable,
    input  o_Mem_Write_Data,
    output i_Mem_Req_Ready,
    output i_Mem_Resp_Valid,
    output i_Mem_Read_Data
  );

endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32/RV64 load/store unit: effective address, alignment and
// funct3 checks, valid/ready memory request, and load lane extraction.
module load_store_unit #(
  parameter int XLEN     = 32,
  parameter int BE_WIDTH = XLEN / 8
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Start,
  input  logic            i_Is_Store,
  input  logic [2:0]      i_Funct3,
  input  logic [XLEN-1:0] i_Base,
  input  logic [XLEN-1:0] i_Offset,
  input  logic [XLEN-1:0] i_Store_Data,
  output logic            o_Busy,
  output logic            o_Done,
  output logic            o_Fault,
  output logic [XLEN-1:0] o_Load_Data,
  load_store_unit_if.master mem
);

  localparam int OFF_W = $clog2(BE_WIDTH);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQUEST   = 3'd1;
  localparam logic [2:0] ST_WAIT_RESP = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  logic [2:0]          state_q,     state_d;
  logic [XLEN-1:0]     addr_q,      addr_d;
  logic [OFF_W-1:0]    off_q,       off_d;
  logic [2:0]          funct3_q,    funct3_d;
  logic                store_q,     store_d;
  logic [BE_WIDTH-1:0] be_q,        be_d;
  logic [XLEN-1:0]     wdata_q,     wdata_d;
  logic [XLEN-1:0]     load_data_q, load_data_d;

  logic [XLEN-1:0]     ea;
  logic [OFF_W-1:0]    ea_off;
  logic                f3_legal;
  logic                misaligned;
  logic [BE_WIDTH-1:0] size_mask;
  logic [XLEN-1:0]     wdata_rep;
  logic [XLEN-1:0]     rd_shifted;
  logic [XLEN-1:0]     load_ext;

  // Effective address wraps modulo 2^XLEN by construction of the adder width.
  assign ea     = i_Base + i_Offset;
  assign ea_off = ea[OFF_W-1:0];

  // Store-only restrictions: the unsigned variants exist for loads only.
  always_comb begin
    case (i_Funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !i_Is_Store;
      3'b011:                 f3_legal = (XLEN == 64);
      3'b110:                 f3_legal = (XLEN == 64) && !i_Is_Store;
      default:                f3_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (i_Funct3[1:0])
      2'b01:   misaligned = ea[0];
      2'b10:   misaligned = |ea[1:0];
      2'b11:   misaligned = |ea[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    case (i_Funct3[1:0])
      2'b00:   size_mask = BE_WIDTH'(8'h01);
      2'b01:   size_mask = BE_WIDTH'(8'h03);
      2'b10:   size_mask = BE_WIDTH'(8'h0F);
      default: size_mask = BE_WIDTH'(8'hFF);
    endcase
  end

  always_comb begin
    case (i_Funct3[1:0])
      2'b00:   wdata_rep = {BE_WIDTH{i_Store_Data[7:0]}};
      2'b01:   wdata_rep = {(XLEN/16){i_Store_Data[15:0]}};
      2'b10:   wdata_rep = {(XLEN/32){i_Store_Data[31:0]}};
      default: wdata_rep = i_Store_Data;
    endcase
  end

  // Addressed lanes moved to bit 0, then sign- or zero-extended by funct3.
  assign rd_shifted = mem.i_Mem_Read_Data >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = XLEN'($signed(rd_shifted[7:0]));
      3'b001:  load_ext = XLEN'($signed(rd_shifted[15:0]));
      3'b010:  load_ext = XLEN'($signed(rd_shifted[31:0]));
      3'b100:  load_ext = XLEN'(rd_shifted[7:0]);
      3'b101:  load_ext = XLEN'(rd_shifted[15:0]);
      3'b110:  load_ext = XLEN'(rd_shifted[31:0]);
      default: load_ext = rd_shifted;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    store_d     = store_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          addr_d   = {ea[XLEN-1:OFF_W], {OFF_W{1'b0}}};
          off_d    = ea_off;
          funct3_d = i_Funct3;
          store_d  = i_Is_Store;
          be_d     = size_mask << ea_off;
          wdata_d  = wdata_rep;
          state_d  = (!f3_legal || misaligned) ? ST_FAULT : ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (mem.i_Mem_Req_Ready) state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (mem.i_Mem_Resp_Valid) begin
          if (!store_q) load_data_d = load_ext;
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_FAULT: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      store_q     <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
    end
  end

  assign o_Busy      = (state_q != ST_IDLE);
  assign o_Done      = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign o_Fault     = (state_q == ST_FAULT);
  assign o_Load_Data = load_data_q;

  // Request fields come straight from registers, so they hold while ready is low.
  assign mem.o_Mem_Req_Valid    = (state_q == ST_REQUEST);
  assign mem.o_Mem_Addr         = addr_q;
  assign mem.o_Mem_Write_Enable = store_q;
  assign mem.o_Mem_Byte_Enable  = be_q;
  assign mem.o_Mem_Write_Data   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one XLEN=32 and one XLEN=64 instance
// driven from a single linear stimulus sequence with hand-computed results.
module tb_load_store_unit;

  logic clk;
  logic rst;

  logic        start32, store32;
  logic [2:0]  f3_32;
  logic [31:0] base32, off32, sdata32;
  logic        busy32, done32, fault32;
  logic [31:0] load32;

  logic        start64, store64;
  logic [2:0]  f3_64;
  logic [63:0] base64, off64, sdata64;
  logic        busy64, done64, fault64;
  logic [63:0] load64;

  int checks   = 0;
  int failures = 0;

  load_store_unit_if #(.XLEN(32)) bus32 ();
  load_store_unit_if #(.XLEN(64)) bus64 ();

  load_store_unit #(.XLEN(32)) u_dut32 (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Start      (start32),
    .i_Is_Store   (store32),
    .i_Funct3     (f3_32),
    .i_Base       (base32),
    .i_Offset     (off32),
    .i_Store_Data (sdata32),
    .o_Busy       (busy32),
    .o_Done       (done32),
    .o_Fault      (fault32),
    .o_Load_Data  (load32),
    .mem          (bus32)
  );

  load_store_unit #(.XLEN(64)) u_dut64 (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Start      (start64),
    .i_Is_Store   (store64),
    .i_Funct3     (f3_64),
    .i_Base       (base64),
    .i_Offset     (off64),
    .i_Store_Data (sdata64),
    .o_Busy       (busy64),
    .o_Done       (done64),
    .o_Fault      (fault64),
    .o_Load_Data  (load64),
    .mem          (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start32 = 1'b0; store32 = 1'b0; f3_32 = 3'd0; base32 = '0; off32 = '0; sdata32 = '0;
    start64 = 1'b0; store64 = 1'b0; f3_64 = 3'd0; base64 = '0; off64 = '0; sdata64 = '0;
    bus32.i_Mem_Req_Ready = 1'b0; bus32.i_Mem_Resp_Valid = 1'b0; bus32.i_Mem_Read_Data = '0;
    bus64.i_Mem_Req_Ready = 1'b0; bus64.i_Mem_Resp_Valid = 1'b0; bus64.i_Mem_Read_Data = '0;
    step(); step();

    // Reset state: every output zero.
    check("rst32_busy",  busy32, 0);
    check("rst32_done",  done32, 0);
    check("rst32_fault", fault32, 0);
    check("rst32_load",  load32, 0);
    check("rst32_valid", bus32.o_Mem_Req_Valid, 0);
    check("rst32_addr",  bus32.o_Mem_Addr, 0);
    check("rst32_we",    bus32.o_Mem_Write_Enable, 0);
    check("rst32_be",    bus32.o_Mem_Byte_Enable, 0);
    check("rst32_wd",    bus32.o_Mem_Write_Data, 0);
    check("rst64_busy",  busy64, 0);
    check("rst64_load",  load64, 0);
    check("rst64_valid", bus64.o_Mem_Req_Valid, 0);
    rst = 1'b0;

    // LB, EA 0x1003: byte lane 3 holds 0x80 -> sign-extended, done at cycle 3.
    bus32.i_Mem_Req_Ready = 1'b1; bus32.i_Mem_Resp_Valid = 1'b1;
    bus32.i_Mem_Read_Data = 32'h80FF_FF00;
    start32 = 1'b1; store32 = 1'b0; f3_32 = 3'b000; base32 = 32'h1000; off32 = 32'd3;
    step(); start32 = 1'b0;
    check("lb_c1_valid", bus32.o_Mem_Req_Valid, 1);
    check("lb_c1_addr",  bus32.o_Mem_Addr, 32'h1000);
    check("lb_c1_be",    bus32.o_Mem_Byte_Enable, 4'b1000);
    check("lb_c1_we",    bus32.o_Mem_Write_Enable, 0);
    check("lb_c1_done",  done32, 0);
    step();
    check("lb_c2_done",  done32, 0);
    check("lb_c2_busy",  busy32, 1);
    step();
    check("lb_c3_done",  done32, 1);
    check("lb_c3_fault", fault32, 0);
    check("lb_c3_load",  load32, 32'hFFFF_FF80);
    step();
    check("lb_idle_busy", busy32, 0);
    check("lb_idle_done", done32, 0);

    // SH at EA 0x2002 with ready held low for 4 cycles.
    bus32.i_Mem_Req_Ready = 1'b0; bus32.i_Mem_Resp_Valid = 1'b0;
    start32 = 1'b1; store32 = 1'b1; f3_32 = 3'b001; base32 = 32'h2002; off32 = 32'd0;
    sdata32 = 32'h1234_ABCD;
    step(); start32 = 1'b0; store32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("sh_hold_valid", bus32.o_Mem_Req_Valid, 1);
      check("sh_hold_addr",  bus32.o_Mem_Addr, 32'h2000);
      check("sh_hold_be",    bus32.o_Mem_Byte_Enable, 4'b1100);
      check("sh_hold_wd",    bus32.o_Mem_Write_Data, 32'hABCD_ABCD);
      check("sh_hold_we",    bus32.o_Mem_Write_Enable, 1);
      step();
    end
    bus32.i_Mem_Req_Ready = 1'b1;
    step();
    check("sh_wait_valid", bus32.o_Mem_Req_Valid, 0);
    check("sh_wait_busy",  busy32, 1);
    bus32.i_Mem_Resp_Valid = 1'b1;
    step();
    check("sh_done",       done32, 1);
    check("sh_fault",      fault32, 0);
    check("sh_load_kept",  load32, 32'hFFFF_FF80);
    step();

    // Misaligned LW at EA 0x6: fault next cycle, no request, load data kept.
    start32 = 1'b1; store32 = 1'b0; f3_32 = 3'b010; base32 = 32'h4; off32 = 32'h2;
    step(); start32 = 1'b0;
    check("mis_valid", bus32.o_Mem_Req_Valid, 0);
    check("mis_done",  done32, 1);
    check("mis_fault", fault32, 1);
    check("mis_load",  load32, 32'hFFFF_FF80);
    step();
    check("mis_idle_busy",  busy32, 0);
    check("mis_idle_valid", bus32.o_Mem_Req_Valid, 0);

    // Store with funct3=100 is illegal.
    start32 = 1'b1; store32 = 1'b1; f3_32 = 3'b100; base32 = 32'h100; off32 = 32'h0;
    step(); start32 = 1'b0; store32 = 1'b0;
    check("sbu_fault", fault32, 1);
    check("sbu_done",  done32, 1);
    check("sbu_valid", bus32.o_Mem_Req_Valid, 0);
    step();

    // funct3=011 (D) is illegal at XLEN=32.
    start32 = 1'b1; f3_32 = 3'b011; base32 = 32'h100; off32 = 32'h0;
    step(); start32 = 1'b0;
    check("ld32_fault", fault32, 1);
    step();

    // LHU with address wrap: 0xFFFFFFFC + 8 = 0x4.
    bus32.i_Mem_Read_Data = 32'hBEEF_8001;
    start32 = 1'b1; f3_32 = 3'b101; base32 = 32'hFFFF_FFFC; off32 = 32'd8;
    step(); start32 = 1'b0;
    check("wrap_addr", bus32.o_Mem_Addr, 32'h0000_0004);
    check("wrap_be",   bus32.o_Mem_Byte_Enable, 4'b0011);
    step(); step();
    check("wrap_done",  done32, 1);
    check("wrap_fault", fault32, 0);
    check("wrap_load",  load32, 32'h0000_8001);
    step();

    // Reset during WAIT_RESP, then a late response must be ignored.
    bus32.i_Mem_Resp_Valid = 1'b0;
    bus32.i_Mem_Read_Data = 32'h1234_5678;
    start32 = 1'b1; f3_32 = 3'b010; base32 = 32'h40; off32 = 32'h0;
    step(); start32 = 1'b0;
    step();
    check("rmid_wait_busy",  busy32, 1);
    check("rmid_wait_valid", bus32.o_Mem_Req_Valid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus32.i_Mem_Resp_Valid = 1'b1;
    check("rmid_busy",  busy32, 0);
    check("rmid_done",  done32, 0);
    check("rmid_load",  load32, 0);
    check("rmid_valid", bus32.o_Mem_Req_Valid, 0);
    step();
    check("rmid_late_done", done32, 0);
    check("rmid_late_busy", busy32, 0);
    step();
    check("rmid_late_done2", done32, 0);

    // Normal LBU after reset; a start pulsed while busy is ignored.
    bus32.i_Mem_Read_Data = 32'h0000_A500;
    start32 = 1'b1; store32 = 1'b0; f3_32 = 3'b100; base32 = 32'h3000; off32 = 32'd1;
    step();
    check("post_addr", bus32.o_Mem_Addr, 32'h3000);
    check("post_be",   bus32.o_Mem_Byte_Enable, 4'b0010);
    store32 = 1'b1; f3_32 = 3'b010; base32 = 32'h5000; off32 = 32'd0;
    step(); start32 = 1'b0; store32 = 1'b0;
    check("busy_start_addr", bus32.o_Mem_Addr, 32'h3000);
    check("busy_start_we",   bus32.o_Mem_Write_Enable, 0);
    step();
    check("post_done",  done32, 1);
    check("post_fault", fault32, 0);
    check("post_load",  load32, 32'h0000_00A5);
    step();
    check("post_idle_busy", busy32, 0);
    check("post_idle_done", done32, 0);

    // XLEN=64 LWU at EA ...0C: upper word zero-extended, lanes 4..7.
    bus64.i_Mem_Req_Ready = 1'b1; bus64.i_Mem_Resp_Valid = 1'b1;
    bus64.i_Mem_Read_Data = 64'hDEAD_BEEF_0000_0000;
    start64 = 1'b1; store64 = 1'b0; f3_64 = 3'b110;
    base64 = 64'h1000_0000_0000_0008; off64 = 64'd4;
    step(); start64 = 1'b0;
    check("lwu64_addr", bus64.o_Mem_Addr, 64'h1000_0000_0000_0008);
    check("lwu64_be",   bus64.o_Mem_Byte_Enable, 8'hF0);
    step(); step();
    check("lwu64_done", done64, 1);
    check("lwu64_load", load64, 64'h0000_0000_DEAD_BEEF);
    step();

    // XLEN=64 SD: all lanes, unreplicated data.
    start64 = 1'b1; store64 = 1'b1; f3_64 = 3'b011; base64 = 64'h100; off64 = 64'd0;
    sdata64 = 64'h0123_4567_89AB_CDEF;
    step(); start64 = 1'b0; store64 = 1'b0;
    check("sd64_be", bus64.o_Mem_Byte_Enable, 8'hFF);
    check("sd64_wd", bus64.o_Mem_Write_Data, 64'h0123_4567_89AB_CDEF);
    check("sd64_we", bus64.o_Mem_Write_Enable, 1);
    step(); step();
    check("sd64_done",  done64, 1);
    check("sd64_fault", fault64, 0);
    step();

    // XLEN=64 LW from the upper word: sign-extended.
    bus64.i_Mem_Read_Data = 64'h8000_0000_0000_0000;
    start64 = 1'b1; f3_64 = 3'b010; base64 = 64'h200; off64 = 64'd4;
    step(); start64 = 1'b0;
    check("lw64_be", bus64.o_Mem_Byte_Enable, 8'hF0);
    step(); step();
    check("lw64_load", load64, 64'hFFFF_FFFF_8000_0000);
    step();
    check("lw64_idle", busy64, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Parametrised multi-cycle load/store unit for the RV32/RV64 datapath, sitting between the execute stage and the data-memory port. It takes one load or store per request, computes the effective address, and checks alignment. It drives a valid/ready memory request with byte enables and lane-replicated store data, then waits for the memory response. For loads it extracts and sign- or zero-extends the addressed lanes. Memory latency is arbitrary, so the unit replaces the fixed single-cycle access path.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
BE_WIDTH, XLEN/8, number of byte enables per memory word (derived; do not override).

Ports:
i_Clock  in  1  clock.
i_Reset  in  1  synchronous reset, active-high.
i_Start  in  1  request strobe; sampled only in IDLE.
i_Is_Store  in  1  1 = store, 0 = load.
i_Funct3  in  3  RISC-V funct3 access type.
i_Base  in  XLEN  base address (rs1).
i_Offset  in  XLEN  immediate offset.
i_Store_Data  in  XLEN  rs2 value.
o_Busy  out  1  high in every state except IDLE.
o_Done  out  1  one-cycle completion pulse.
o_Fault  out  1  valid with o_Done: misaligned or illegal funct3.
o_Load_Data  out  XLEN  extended load result; valid with o_Done and held until the next accepted i_Start.
o_Mem_Req_Valid  out  1  memory request valid.
i_Mem_Req_Ready  in  1  memory accepts request.
o_Mem_Addr  out  XLEN  word-aligned address (low log2(BE_WIDTH) bits are 0).
o_Mem_Write_Enable  out  1  1 for store requests.
o_Mem_Byte_Enable  out  BE_WIDTH  active byte lanes.
o_Mem_Write_Data  out  XLEN  lane-replicated store data.
i_Mem_Resp_Valid  in  1  response (read data or write ack).
i_Mem_Read_Data  in  XLEN  read data, valid with i_Mem_Resp_Valid.

Behaviour:
- Reset: state IDLE; every output 0, including o_Load_Data.
- Reset mid-operation: the next state is IDLE and o_Mem_Req_Valid drops. Any later i_Mem_Resp_Valid is ignored.
- Effective address EA = i_Base + i_Offset, modulo 2^XLEN (wrap, no fault).
- Legal funct3 (both widths): 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Legal funct3 (XLEN=64 only): 011 D and 110 WU.
- Stores are legal only for B/H/W (and D at XLEN=64). All other funct3 values are illegal.
- Misaligned: H/HU with EA[0]=1; W/WU with EA[1:0]!=0; D with EA[2:0]!=0.
- FSM: IDLE -> REQUEST -> WAIT_RESP -> DONE -> IDLE; FAULT -> IDLE.
- IDLE: on i_Start, latch EA, funct3, store flag and data. Go to FAULT if the request is illegal or misaligned, otherwise go to REQUEST.
- i_Start outside IDLE is ignored.
- REQUEST: o_Mem_Req_Valid=1. Address, write enable, byte enables and write data are held stable until i_Mem_Req_Ready is sampled high, then go to WAIT_RESP.
- WAIT_RESP: stay until i_Mem_Resp_Valid, then go to DONE. For loads, capture and extend the data on that edge. A response asserted during REQUEST is ignored.
- DONE: o_Done=1 for one cycle, o_Fault=0.
- FAULT: o_Done=1 and o_Fault=1 for one cycle. No memory request is issued and o_Load_Data is unchanged.
- Byte enables: access size 1, 2, 4 or 8 bytes, shifted left by the byte offset EA[log2(BE_WIDTH)-1:0].
- Write data: the low 8, 16 or 32 bits of i_Store_Data are replicated across all lanes.
- Load extract: shift i_Mem_Read_Data right by 8*offset, then sign-extend (B/H/W) or zero-extend (BU/HU/WU). D returns the full word.
- Latency: minimum 3 cycles from i_Start to o_Done (ready and response immediate); a fault takes 1 cycle. A new i_Start is accepted in the cycle after o_Done.

Test Plan:
- XLEN=32 LB: Base 0x1000, Offset 3, read data 0x80FF_FF00, ready and response immediate -> byte enable 0b1000, address 0x1000, o_Load_Data 0xFFFF_FF80, o_Done exactly 3 cycles after i_Start.
- XLEN=32 SH: Base 0x2002, Offset 0, data 0x1234_ABCD -> write data 0xABCD_ABCD, byte enable 0b1100, write enable 1. Hold ready low for 4 cycles: request fields must stay stable throughout.
- Misaligned LW at EA 0x0000_0006 -> no o_Mem_Req_Valid, o_Done=o_Fault=1 on the next cycle, o_Load_Data unchanged. Store funct3=100 also faults.
- Wrap: Base 0xFFFF_FFFC, Offset 8, LHU, read data 0xBEEF_8001 -> address 0x0000_0004, o_Load_Data 0x0000_8001.
- XLEN=64 LWU at EA 0x...0C, read data 0xDEAD_BEEF_0000_0000 -> o_Load_Data 0x0000_0000_DEAD_BEEF, byte enable 0xF0.
- Assert i_Reset during WAIT_RESP, then pulse i_Mem_Resp_Valid -> no o_Done, unit IDLE. A following i_Start is served normally; i_Start pulsed while busy is ignored.
